// File: rtl/glyph_rom_pkg.sv
// Shared constants for the glyph ROM arbiter: requester ids, widths and
// the base offset of each glyph set inside the merged font ROM.
package glyph_rom_pkg;

  localparam int GLYPH_ADDR_W = 10;
  localparam int GLYPH_DATA_W = 64;

  localparam int REQ_HANZI  = 0;
  localparam int REQ_SHUZI  = 1;
  localparam int REQ_DANWEI = 2;
  localparam int REQ_TITLE  = 3;

  typedef enum logic [1:0] {
    GLYPH_HANZI  = 2'd0,
    GLYPH_SHUZI  = 2'd1,
    GLYPH_DANWEI = 2'd2,
    GLYPH_TITLE  = 2'd3
  } glyph_set_e;

  localparam logic [GLYPH_ADDR_W-1:0] BASE_HANZI  = 10'd0;
  localparam logic [GLYPH_ADDR_W-1:0] BASE_SHUZI  = 10'd512;
  localparam logic [GLYPH_ADDR_W-1:0] BASE_DANWEI = 10'd768;
  localparam logic [GLYPH_ADDR_W-1:0] BASE_TITLE  = 10'd896;

  function automatic logic [GLYPH_ADDR_W-1:0] glyph_base(input glyph_set_e set);
    case (set)
      GLYPH_HANZI:  glyph_base = BASE_HANZI;
      GLYPH_SHUZI:  glyph_base = BASE_SHUZI;
      GLYPH_DANWEI: glyph_base = BASE_DANWEI;
      default:      glyph_base = BASE_TITLE;
    endcase
  endfunction

endpackage

// File: rtl/glyph_rom_arbiter_if.sv
// Bundle between the glyph fetch units / font ROM (master) and the arbiter (slave).
interface glyph_rom_arbiter_if
  import glyph_rom_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = GLYPH_ADDR_W,
  parameter int DATA_W = GLYPH_DATA_W
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]       rom_addr;
  logic [DATA_W-1:0]       rom_q;
  logic [N_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]       rd_data;
  logic                    busy;

  modport master (
    output req, req_addr, rom_q,
    input  gnt, rom_addr, rd_valid, rd_data, busy
  );

  modport slave (
    input  req, req_addr, rom_q,
    output gnt, rom_addr, rd_valid, rd_data, busy
  );
endinterface

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter_n #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [PTR_W-1:0] ptr,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] win,
  output logic             any
);
  int idx;

  always_comb begin
    gnt = '0;
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      // Explicit wrap so non-power-of-two N never aliases onto missing requesters.
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        win      = PTR_W'(idx);
      end
    end
  end
endmodule

// File: rtl/glyph_rom_arbiter.sv
// Round-robin sharing of one synchronous glyph ROM; a tag pipe steers each
// returned row back to the requester that was granted ROM_LAT+1 cycles earlier.
module glyph_rom_arbiter
  import glyph_rom_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = GLYPH_ADDR_W,
  parameter int DATA_W  = GLYPH_DATA_W,
  parameter int ROM_LAT = 1
) (
  input logic clk,
  input logic rst,
  glyph_rom_arbiter_if.slave bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DEPTH = ROM_LAT + 1;

  logic [PTR_W-1:0]            ptr_q, ptr_d, win;
  logic [N_REQ-1:0]            arb_gnt;
  logic                        any, grant;
  logic [ADDR_W-1:0]           rom_addr_q, rom_addr_d;
  logic [DEPTH-1:0]            tag_vld_q, tag_vld_d;
  logic [DEPTH-1:0][N_REQ-1:0] tag_id_q, tag_id_d;
  logic [DATA_W-1:0]           rd_data_q, rd_data_d;

  rr_arbiter_n #(.N(N_REQ), .PTR_W(PTR_W)) u_rr (
    .ptr (ptr_q),
    .req (bus.req),
    .gnt (arb_gnt),
    .win (win),
    .any (any)
  );

  always_comb begin
    grant      = any & ~rst;
    ptr_d      = ptr_q;
    rom_addr_d = rom_addr_q;
    if (grant) begin
      ptr_d      = (win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1);
      rom_addr_d = bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
    end
    // Index 0 is the tag captured at the grant edge; index DEPTH-1 drives rd_valid.
    tag_vld_d = {tag_vld_q[DEPTH-2:0], grant};
    tag_id_d  = {tag_id_q[DEPTH-2:0], arb_gnt};
    rd_data_d = tag_vld_q[ROM_LAT-1] ? bus.rom_q : rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      rom_addr_q <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      rd_data_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rom_addr_q <= rom_addr_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.gnt      = grant ? arb_gnt : '0;
  assign bus.rom_addr = rom_addr_d;
  assign bus.rd_valid = tag_vld_q[DEPTH-1] ? tag_id_q[DEPTH-1] : '0;
  assign bus.rd_data  = rd_data_q;
  assign bus.busy     = |tag_vld_q;
endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// Bench for glyph_rom_arbiter: directed scenarios with literal expectations
// plus randomized requesters checked every cycle against a reference model.
module tb_glyph_rom_arbiter;
  localparam int N   = 4;
  localparam int AW  = 10;
  localparam int DW  = 64;
  localparam int MAXC = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  glyph_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  glyph_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ROM with one cycle latency: q = registered address * 3
  logic [AW-1:0] rom_reg = '0;
  always @(posedge clk) rom_reg <= bus.rom_addr;
  assign bus.rom_q = 64'(rom_reg) * 64'd3;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference model state
  int            m_ptr = 0;
  int            m_win;
  logic [AW-1:0] m_last_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [N-1:0]  exp_rv   [MAXC];
  logic [DW-1:0] exp_dat  [MAXC];
  bit            exp_busy [MAXC];

  logic [N-1:0]  obs_gnt, obs_rv;
  logic [DW-1:0] obs_data;
  logic          obs_busy;
  logic [AW-1:0] obs_addr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [N*AW-1:0] mk(input int a0, input int a1, input int a2, input int a3);
    mk = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  task automatic step(input logic [N-1:0] r, input logic [N*AW-1:0] a, input logic rs);
    logic [AW-1:0] sl;
    @(negedge clk);
    cyc++;
    rst = rs;
    if (rs) begin
      for (int c = cyc; c < MAXC; c++) begin
        exp_rv[c]   = '0;
        exp_busy[c] = 1'b0;
      end
      m_data      = '0;
      m_ptr       = 0;
      m_last_addr = '0;
    end
    #1;
    obs_rv   = bus.rd_valid;
    obs_data = bus.rd_data;
    obs_busy = bus.busy;
    if (exp_rv[cyc] != '0) m_data = exp_dat[cyc];
    chk("rd_valid", 64'(obs_rv), 64'(exp_rv[cyc]));
    chk("rd_data", obs_data, m_data);
    chk("busy", 64'(obs_busy), 64'(exp_busy[cyc]));

    bus.req      = r;
    bus.req_addr = a;
    #1;
    obs_gnt  = bus.gnt;
    obs_addr = bus.rom_addr;
    m_win    = -1;
    if (!rs) begin
      for (int k = 0; k < N; k++) begin
        if (m_win < 0 && r[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
      end
    end
    chk("gnt", 64'(obs_gnt), (m_win < 0) ? 64'd0 : (64'd1 << m_win));
    if (m_win >= 0) begin
      sl          = a[m_win*AW +: AW];
      m_last_addr = sl;
      m_ptr       = (m_win + 1) % N;
      if (cyc + 2 < MAXC) begin
        exp_rv[cyc+2]   = N'(1) << m_win;
        exp_dat[cyc+2]  = 64'(sl) * 64'd3;
        exp_busy[cyc+1] = 1'b1;
        exp_busy[cyc+2] = 1'b1;
      end
    end
    if (!rs) chk("rom_addr", 64'(obs_addr), 64'(m_last_addr));
  endtask

  logic [N*AW-1:0] A;
  logic [N-1:0]    gseq [7];
  logic [N-1:0]    pend;
  logic [AW-1:0]   raddr [N];

  initial begin
    for (int c = 0; c < MAXC; c++) begin
      exp_rv[c] = '0; exp_dat[c] = '0; exp_busy[c] = 1'b0;
    end
    bus.req = '0;
    bus.req_addr = '0;
    A = mk(100, 107, 114, 121);

    // reset with every requester asserting
    step(4'b1111, A, 1'b1);
    chk("rst_gnt", 64'(obs_gnt), 64'd0);
    step(4'b1111, A, 1'b1);
    chk("rst_rv", 64'(obs_rv), 64'd0);
    step(4'b1111, A, 1'b0);
    chk("first_gnt", 64'(obs_gnt), 64'b0001);
    chk("first_addr", 64'(obs_addr), 64'd100);

    // all requesters held: strict rotation
    gseq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 7; i++) begin
      step(4'b1111, A, 1'b0);
      chk("rot_gnt", 64'(obs_gnt), 64'(gseq[i]));
    end
    step(4'b0000, A, 1'b0);
    step(4'b0000, A, 1'b0);

    // single read from requester 2 at 770
    step(4'b0100, mk(0, 0, 770, 0), 1'b0);
    chk("t3_gnt", 64'(obs_gnt), 64'b0100);
    step(4'b0000, A, 1'b0);
    chk("t3_busy1", 64'(obs_busy), 64'd1);
    step(4'b0000, A, 1'b0);
    chk("t3_rv", 64'(obs_rv), 64'b0100);
    chk("t3_data", obs_data, 64'd2310);
    chk("t3_busy2", 64'(obs_busy), 64'd1);
    step(4'b0000, A, 1'b0);
    chk("t3_idle", 64'(obs_busy), 64'd0);
    chk("t3_hold", obs_data, 64'd2310);

    // back-to-back grants 1 then 3
    step(4'b0010, A, 1'b0);
    step(4'b1000, A, 1'b0);
    step(4'b0000, A, 1'b0);
    chk("t4_rv1", 64'(obs_rv), 64'b0010);
    chk("t4_d1", obs_data, 64'd321);
    step(4'b0000, A, 1'b0);
    chk("t4_rv3", 64'(obs_rv), 64'b1000);
    chk("t4_d3", obs_data, 64'd363);

    // pointer at 3, then lone requester 0
    step(4'b0100, A, 1'b0);
    step(4'b1001, A, 1'b0);
    chk("t5_g3", 64'(obs_gnt), 64'b1000);
    step(4'b1001, A, 1'b0);
    chk("t5_g0", 64'(obs_gnt), 64'b0001);
    for (int i = 0; i < 3; i++) begin
      step(4'b0001, A, 1'b0);
      chk("t5_solo", 64'(obs_gnt), 64'b0001);
    end
    step(4'b0000, A, 1'b0);
    step(4'b0000, A, 1'b0);

    // reset one cycle after a grant discards the read
    step(4'b0010, A, 1'b0);
    step(4'b0000, A, 1'b1);
    chk("t6_rv_rst", 64'(obs_rv), 64'd0);
    step(4'b0000, A, 1'b1);
    chk("t6_busy", 64'(obs_busy), 64'd0);
    step(4'b0000, A, 1'b0);
    chk("t6_rv_after", 64'(obs_rv), 64'd0);
    step(4'b0000, A, 1'b0);
    chk("t6_rv_late", 64'(obs_rv), 64'd0);
    chk("t6_data", obs_data, 64'd0);

    // randomized requesters obeying hold-until-grant
    pend = '0;
    for (int i = 0; i < N; i++) raddr[i] = '0;
    for (int n = 0; n < 400; n++) begin
      logic rs;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]  = 1'b1;
          raddr[i] = AW'($urandom_range(0, 1023));
        end
      end
      rs = ($urandom_range(0, 59) == 0);
      step(pend, {raddr[3], raddr[2], raddr[1], raddr[0]}, rs);
      if (m_win >= 0) begin
        if ($urandom_range(0, 1) == 1) raddr[m_win] = AW'($urandom_range(0, 1023));
        else pend[m_win] = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) step(4'b0000, A, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
